// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-by-16 restoring divider.
//   N       : divisor / quotient / remainder width (dividend is 2*N bits)
//   CW      : width of the step counter that counts the N restoring steps
//   state_t : controller states, also exported on the debug port
package div_pkg;
  localparam int N  = 16;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_32by16_seq_if.sv
// Operand/result bus of the divider.
// Handshake rules, identical on both ends: a transfer happens at a rising clock
// edge where valid and ready are both high. The producer holds its data stable
// while valid is high and ready is low; the consumer may drive ready at any time.
//   in_valid / in_ready   : operand channel (dividend, divisor)
//   out_valid / out_ready : result channel (quotient, remainder, ovf, dbz)
// Modports: master = operand producer and result consumer, slave = the divider.
interface div_32by16_seq_if;
  import div_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [2*N-1:0]     dividend;
  logic [N-1:0]       divisor;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       quotient;
  logic [N-1:0]       remainder;
  logic               ovf;
  logic               dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   r       : partial remainder before the step (always < divisor)
//   bit_in  : next dividend bit shifted into the remainder
//   divisor : divisor
//   r_next  : partial remainder after the step
//   q_bit   : quotient bit produced by this step
module div_step
  import div_pkg::*;
(
  input  logic [N-1:0] r,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_next,
  output logic         q_bit
);
  logic [N:0]   shifted;
  logic [N-1:0] trial;

  assign shifted = {r, bit_in};
  // Because r < divisor, shifted < 2*divisor, so whenever the subtraction
  // succeeds its result fits in N bits and the low N bits are exact.
  assign trial   = shifted[N-1:0] - divisor;
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign r_next  = q_bit ? trial : shifted[N-1:0];
endmodule

// File: rtl/div_32by16_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder, one quotient bit per clock.
//   clk       : clock, all state on the rising edge
//   rst       : synchronous active-high reset
//   bus       : operand/result handshake bus (slave side)
//   state_dbg : current controller state
// Divide-by-zero and quotient overflow are detected at acceptance and skip the
// iteration entirely; the result then appears at the accepting edge.
module div_32by16_seq
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  div_32by16_seq_if.slave      bus,
  output state_t               state_dbg
);
  state_t         state, next_state;
  logic           accept, calc_last;
  logic           in_dbz, in_ovf;

  logic [N-1:0]   r_q;        // partial remainder
  logic [N-1:0]   q_q;        // low dividend bits shifting out, quotient bits shifting in
  logic [N-1:0]   div_q;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   quotient_q, remainder_q;
  logic           ovf_q, dbz_q;

  logic [N-1:0]   step_r;
  logic           step_bit;

  div_step u_step (
    .r       (r_q),
    .bit_in  (q_q[N-1]),
    .divisor (div_q),
    .r_next  (step_r),
    .q_bit   (step_bit)
  );

  assign in_dbz = (bus.divisor == '0);
  // Quotient fits in N bits exactly when the upper dividend half is below the divisor.
  assign in_ovf = (bus.dividend[2*N-1:N] >= bus.divisor);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    calc_last  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          next_state = (in_dbz || in_ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(N - 1)) begin
          calc_last  = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      div_q       <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      r_q   <= bus.dividend[2*N-1:N];
      q_q   <= bus.dividend[N-1:0];
      div_q <= bus.divisor;
      cnt   <= '0;
      if (in_dbz) begin
        dbz_q       <= 1'b1;
        ovf_q       <= 1'b0;
        quotient_q  <= '1;
        remainder_q <= '0;
      end else if (in_ovf) begin
        dbz_q       <= 1'b0;
        ovf_q       <= 1'b1;
        quotient_q  <= '1;
        remainder_q <= '0;
      end
    end else if (state == CALC) begin
      r_q <= step_r;
      q_q <= {q_q[N-2:0], step_bit};
      cnt <= cnt + CW'(1);
      if (calc_last) begin
        quotient_q  <= {q_q[N-2:0], step_bit};
        remainder_q <= step_r;
        ovf_q       <= 1'b0;
        dbz_q       <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_div_32by16_seq.sv
module tb_div_32by16_seq;
  import div_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;

  div_32by16_seq_if bus ();

  div_32by16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result packed as {ovf, dbz, quotient, remainder}.
  function automatic logic [33:0] model(input logic [31:0] dd, input logic [15:0] dv);
    logic [31:0] q;
    logic [31:0] r;
    if (dv == 16'd0) return {1'b0, 1'b1, 16'hFFFF, 16'h0000};
    q = dd / {16'd0, dv};
    r = dd % {16'd0, dv};
    if (q > 32'h0000FFFF) return {1'b1, 1'b0, 16'hFFFF, 16'h0000};
    return {2'b00, q[15:0], r[15:0]};
  endfunction

  // Negedges between the accept decision and the first negedge with out_valid.
  function automatic int model_lat(input logic [31:0] dd, input logic [15:0] dv);
    if (dv == 16'd0) return 1;
    if ((dd / {16'd0, dv}) > 32'h0000FFFF) return 1;
    return N + 1;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [33:0] exp_q[$];
  int          t = 0;
  int          acc_t = 0;
  int          exp_lat = 0;
  bit          outstanding = 1'b0;

  always @(negedge clk) begin
    t++;
    if (rst) begin
      exp_q.delete();
      outstanding = 1'b0;
    end else begin
      check("in_ready", {33'd0, bus.in_ready}, {33'd0, !outstanding});
      check("out_valid", {33'd0, bus.out_valid},
            {33'd0, (outstanding && (t - acc_t >= exp_lat))});
      if (bus.out_valid && outstanding && exp_q.size() > 0) begin
        check("result", {bus.ovf, bus.dbz, bus.quotient, bus.remainder}, exp_q[0]);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          outstanding = 1'b0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.dividend, bus.divisor));
        exp_lat     = model_lat(bus.dividend, bus.divisor);
        acc_t       = t;
        outstanding = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
  endtask

  task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, input int hold,
                        input bit noisy, output logic [15:0] q, output logic [15:0] r,
                        output logic o, output logic z, output int lat);
    bit ok;
    q = '0; r = '0; o = 1'b0; z = 1'b0; lat = -1;
    bus.dividend  = dd;
    bus.divisor   = dv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) begin
      check("accept_timeout", 34'd0, 34'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (noisy) scramble();
    else bus.in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
      @(posedge clk); #1;
      if (noisy) scramble();
    end
    if (!ok) begin
      check("result_timeout", 34'd0, 34'd1);
      bus.in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (noisy) scramble();
    end
    if (hold > 0) check("hold_valid", {33'd0, bus.out_valid}, 34'd1);
    q = bus.quotient;
    r = bus.remainder;
    o = bus.ovf;
    z = bus.dbz;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] q, r, q0, r0, a, b;
    logic        o, z;
    int          lat;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", {33'd0, bus.in_ready}, 34'd1);
    check("reset_out_valid", {33'd0, bus.out_valid}, 34'd0);
    check("reset_outputs", {bus.ovf, bus.dbz, bus.quotient, bus.remainder}, 34'd0);

    // 1: exact division, latency N
    run_op(32'd150000, 16'd300, 0, 1'b0, q, r, o, z, lat);
    check("t1_result", {o, z, q, r}, {2'b00, 16'd500, 16'd0});
    check("t1_latency", 34'(lat), 34'd16);

    // 2: largest legal product round trip
    run_op(32'hFFFE0001, 16'hFFFF, 0, 1'b0, q, r, o, z, lat);
    check("t2_result", {o, z, q, r}, {2'b00, 16'hFFFF, 16'd0});

    // 3: back-pressure, outputs stable across the hold
    run_op(32'd1000, 16'd7, 0, 1'b0, q0, r0, o, z, lat);
    check("t3_first", {o, z, q0, r0}, {2'b00, 16'd142, 16'd6});
    run_op(32'd1000, 16'd7, 5, 1'b0, q, r, o, z, lat);
    check("t3_after_hold", {o, z, q, r}, {2'b00, 16'd142, 16'd6});

    // 4: exceptions, result at the accepting edge
    run_op(32'd1234, 16'd0, 0, 1'b0, q, r, o, z, lat);
    check("t4_dbz", {o, z, q, r}, {2'b01, 16'hFFFF, 16'd0});
    check("t4_dbz_latency", 34'(lat), 34'd0);
    run_op(32'h00010000, 16'd1, 0, 1'b0, q, r, o, z, lat);
    check("t4_ovf", {o, z, q, r}, {2'b10, 16'hFFFF, 16'd0});
    check("t4_ovf_latency", 34'(lat), 34'd0);

    // 5: reset during iteration step 8
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t5_in_calc", {32'd0, state_dbg}, {32'd0, CALC});
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_state", {32'd0, state_dbg}, {32'd0, IDLE});
    check("t5_in_ready", {33'd0, bus.in_ready}, 34'd1);
    check("t5_out_valid", {33'd0, bus.out_valid}, 34'd0);
    check("t5_outputs", {bus.ovf, bus.dbz, bus.quotient, bus.remainder}, 34'd0);
    run_op(32'd1000, 16'd7, 0, 1'b0, q, r, o, z, lat);
    check("t5_fresh", {o, z, q, r}, {2'b00, 16'd142, 16'd6});

    // 6: random multiplier round trips with back-pressure and in_valid noise
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      run_op({16'd0, a} * {16'd0, b}, b, $urandom_range(0, 3), 1'b1, q, r, o, z, lat);
      check("t6_roundtrip", {o, z, q, r}, {2'b00, a, 16'd0});
    end

    repeat (3) @(posedge clk);
    check("end_queue_empty", 34'(exp_q.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
